// File: rtl/seq_detector_param.sv
// Run-time programmable serial sequence detector with valid-qualified input,
// overlap/non-overlap modes and a saturating match counter.
module seq_detector_param #(
  parameter int PATTERN_W = 12,
  parameter int CNT_W     = 8,
  localparam int LEN_W    = $clog2(PATTERN_W + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 seq_in,
  input  logic                 seq_valid,
  input  logic                 pat_load,
  input  logic [PATTERN_W-1:0] pat_value,
  input  logic [LEN_W-1:0]     pat_len,
  input  logic                 overlap_en,
  input  logic                 clr_count,
  output logic                 match,
  output logic [CNT_W-1:0]     match_count,
  output logic                 count_sat,
  output logic                 armed
);

  typedef enum logic [1:0] {UNLOADED, FILLING, DETECTING} state_t;

  state_t               state;
  state_t               next_state;
  logic [PATTERN_W-1:0] pat_r;
  logic [LEN_W-1:0]     len_r;
  logic                 ovl_r;
  // The oldest history bit is shifted out before it can ever be compared,
  // so only PATTERN_W-1 bits are kept; the compare uses the shifted value.
  logic [PATTERN_W-2:0] hist;
  logic [LEN_W-1:0]     fill;

  logic                 accept;
  logic [PATTERN_W-1:0] hist_next;
  logic [PATTERN_W-1:0] len_mask;
  logic                 hit;
  logic                 complete;
  logic                 match_set;
  logic                 restart;
  logic [LEN_W-1:0]     fill_inc;
  logic [LEN_W-1:0]     len_eff;

  always_comb begin
    accept    = seq_valid && !pat_load && (state != UNLOADED);
    hist_next = {hist, seq_in};
    for (int i = 0; i < PATTERN_W; i++) begin
      len_mask[i] = (i < int'(len_r));
    end
    hit       = ((hist_next ^ pat_r) & len_mask) == '0;
    fill_inc  = fill + LEN_W'(1);
    complete  = (state == DETECTING) || ((state == FILLING) && (fill_inc == len_r));
    match_set = accept && complete && hit;
    restart   = match_set && !ovl_r;
    if ((pat_len == '0) || (pat_len > LEN_W'(PATTERN_W))) begin
      len_eff = LEN_W'(PATTERN_W);
    end else begin
      len_eff = pat_len;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= UNLOADED;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (pat_load) begin
      next_state = FILLING;
    end else if (accept) begin
      case (state)
        FILLING:   if (complete) next_state = restart ? FILLING : DETECTING;
        DETECTING: if (restart) next_state = FILLING;
        default:   next_state = state;
      endcase
    end
  end

  always_comb begin
    armed     = (state == DETECTING);
    count_sat = &match_count;
  end

  // A load discards any bit offered in the same cycle and restarts the fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_r <= '0;
      len_r <= '0;
      ovl_r <= 1'b0;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (pat_load) begin
      pat_r <= pat_value;
      len_r <= len_eff;
      ovl_r <= overlap_en;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (accept) begin
      hist  <= hist_next[PATTERN_W-2:0];
      match <= complete && hit;
      if (restart) begin
        fill <= '0;
      end else if (fill != len_r) begin
        fill <= fill_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
    end else if (clr_count) begin
      match_count <= '0;
    end else if (match_set && !count_sat) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial sequence detector; successor to the fixed 12-bit, hard-coded-pattern detectors used in the autograding flow.
- Pattern, active length and overlap mode are loaded at run time.
- Input bits are qualified by a valid strobe; the block counts matches with saturation.
- Sits between a serial bit source and the grading/monitor logic.

Parameters:
- PATTERN_W, 12, maximum pattern length in bits (legal 2..32).
- CNT_W, 8, width of match counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- seq_in  in  1  serial input bit.
- seq_valid  in  1  seq_in is sampled on a posedge only when this is high.
- pat_load  in  1  one-cycle strobe; loads pat_value, pat_len, overlap_en.
- pat_value  in  PATTERN_W  pattern; bit [pat_len-1] is the first bit expected, bit 0 the last.
- pat_len  in  $clog2(PATTERN_W+1)  active pattern length L.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- clr_count  in  1  synchronous clear of match_count/count_sat.
- match  out  1  registered detect flag.
- match_count  out  CNT_W  number of matches since reset/clear, saturating.
- count_sat  out  1  high while match_count is all-ones.
- armed  out  1  high when a pattern is loaded and at least L valid bits have been received.

Behaviour:
- Reset (reset low, async): state UNLOADED; pattern, length, mode, history, fill counter = 0; match, match_count, count_sat, armed = 0.
- History register hist[PATTERN_W-1:0]: on each accepted bit, hist <= {hist[PATTERN_W-2:0], seq_in}. The newest bit is hist[0].
- Fill counter: counts accepted bits since load or last non-overlap match; saturates at L.
- Length rule: pat_len of 0 or greater than PATTERN_W is latched as PATTERN_W.
- Compare: low L bits of the next hist value equal low L bits of the latched pattern. Upper bits are ignored.
- FSM states:
  - UNLOADED: seq_valid ignored; match = 0. pat_load -> FILLING.
  - FILLING: each accepted bit increments fill. When the bit that makes fill = L is accepted -> DETECTING, and match is evaluated on that same edge.
  - DETECTING: each accepted bit updates match = compare result.
    - On match with overlap_en = 0: fill <= 0, go to FILLING, so the next match needs L fresh bits.
    - On match with overlap_en = 1: stay in DETECTING.
- match timing:
  - Updated only on posedges with seq_valid = 1 in FILLING/DETECTING.
  - Holds its value through seq_valid-low gaps.
  - Always 0 before the L-th accepted bit after load; never set early.
  - Visible from the same posedge that accepts the completing bit, so it is stable at the following negedge.
- armed: 1 in DETECTING. In non-overlap mode it drops to 0 after each match.
- Counter:
  - match_count increments by 1 on every posedge where match is written to 1.
  - Holds at 2^CNT_W-1; count_sat = (match_count == all-ones).
  - clr_count zeroes match_count; clear wins over a simultaneous increment.
- pat_load on any state: latches the new config; clears hist, fill and match; goes to FILLING. match_count is not affected.
- pat_load with seq_valid in the same cycle: load wins and the bit is discarded.
- reset mid-stream: immediate return to the reset values. A pattern must be reloaded before any detection.

Test Plan:
- Load pat_value=12'hA5C, L=12, overlap=0; feed bits 1,0,1,0,0,1,0,1,1,1,0,0 (one per cycle, seq_valid=1) -> match=0 through bit 11; match=1 after bit 12; match_count=1; armed=0 afterwards.
- Same load; feed 12'hA5C<<1 (truncated to 12'h4B8) and then 12'hA5C>>1 (12'h52E), each after a reset and reload -> match stays 0 for all 24 cycles; match_count=0.
- Load 3'b111, L=3: feed six 1s with overlap_en=1 -> match=1 on bits 3,4,5,6, match_count=4. Repeat with overlap_en=0 -> match=1 only on bits 3 and 6, match_count=2.
- L=12 pattern 12'hA5C with seq_valid low for 3 cycles between bits 6 and 7 -> match result unchanged vs. contiguous feed; match held stable during gaps.
- Drive reset low for 1 cycle after bit 8, then reload and feed the full pattern -> all outputs 0 during reset; a single match after the 12th post-reload bit.
- CNT_W=2, L=1, pattern 1'b1, overlap=1: feed five 1s -> match_count 1,2,3,3,3 and count_sat=1 from the 3rd match. Assert clr_count together with a 6th matching bit -> match_count=0, count_sat=0.
